// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: multi-cycle RV32M sequencer for the EX stage.
// Runs one MUL/DIV-class op at a time. Multiplies use a radix-2
// shift-add loop and divides a restoring loop, each over magnitudes.
// A final fix-up cycle applies the signs. Divide-by-zero and signed
// overflow finish in one cycle without iterating.
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_valid/i_func3/i_rs1/i_rs2 : op request, held stable until o_valid
//   i_flush  : kill the in-flight op
//   o_stall  : i_valid & ~o_valid, freezes IF/ID/EX
//   o_busy   : sequencer not idle
//   o_valid  : one-cycle result strobe
//   o_result : result, holds its last value between strobes
module ex_muldiv_seq #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_valid,
  input  logic [2:0]      i_func3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             loaded_q;
  logic [2:0]       func_q;
  logic             neg_a_q, neg_b_q;
  logic [XLEN-1:0]  mag_a_q, mag_b_q;
  logic [XLEN-1:0]  hi_q, lo_q;
  logic [XLEN-1:0]  result_q;

  // Operand decode at accept
  logic            sgn_a, sgn_b, in_neg_a, in_neg_b;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_res;
  logic            last_iter;

  // Iteration and fix-up datapath
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  always_comb begin
    sgn_a    = (i_func3 == 3'b001) || (i_func3 == 3'b010) ||
               (i_func3 == 3'b100) || (i_func3 == 3'b110);
    sgn_b    = (i_func3 == 3'b001) || (i_func3 == 3'b100) ||
               (i_func3 == 3'b110);
    in_neg_a = sgn_a & i_rs1[XLEN-1];
    in_neg_b = sgn_b & i_rs2[XLEN-1];
    div_zero = i_func3[2] && (i_rs2 == '0);
    div_ovf  = ((i_func3 == 3'b100) || (i_func3 == 3'b110)) &&
               (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_rs2 == '1);
    fast     = div_zero | div_ovf;
    if (div_zero) fast_res = i_func3[1] ? i_rs1 : '1;
    else          fast_res = i_func3[1] ? '0 : i_rs1;
  end

  always_comb begin
    last_iter = loaded_q && (cnt_q == CNT_W'(XLEN-1));
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_a_q} : '0);
    div_sh    = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_sh - {1'b0, mag_b_q};
    prod      = {hi_q, lo_q};
    prod_fix  = (neg_a_q ^ neg_b_q) ? -prod : prod;
    quo_fix   = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
    rem_fix   = neg_a_q ? -hi_q : hi_q;
    if (func_q[2])            fix_res = func_q[1] ? rem_fix : quo_fix;
    else if (func_q == 3'b000) fix_res = prod_fix[XLEN-1:0];
    else                       fix_res = prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    o_busy  = (state_q != ST_IDLE);
    o_valid = (state_q == ST_DONE);
    o_stall = i_valid & ~o_valid;
    case (state_q)
      ST_IDLE: if (i_valid) state_d = fast ? ST_DONE : (i_func3[2] ? ST_DIV : ST_MUL);
      ST_MUL,
      ST_DIV:  if (last_iter) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (i_flush) state_d = ST_IDLE;
  end

  // The first MUL/DIV cycle loads the accumulator from the latched
  // magnitudes; the 32 iterations (cnt 0..31) follow it.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q    <= '0;
      loaded_q <= 1'b0;
      func_q   <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else if (i_flush) begin
      cnt_q    <= '0;
      loaded_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (i_valid) begin
          func_q   <= i_func3;
          neg_a_q  <= in_neg_a;
          neg_b_q  <= in_neg_b;
          mag_a_q  <= in_neg_a ? -i_rs1 : i_rs1;
          mag_b_q  <= in_neg_b ? -i_rs2 : i_rs2;
          cnt_q    <= '0;
          loaded_q <= 1'b0;
          if (fast) result_q <= fast_res;
        end
        ST_MUL: if (!loaded_q) begin
          hi_q     <= '0;
          lo_q     <= mag_b_q;
          loaded_q <= 1'b1;
        end else begin
          hi_q  <= mul_sum[XLEN:1];
          lo_q  <= {mul_sum[0], lo_q[XLEN-1:1]};
          cnt_q <= cnt_q + CNT_W'(1);
        end
        ST_DIV: if (!loaded_q) begin
          hi_q     <= '0;
          lo_q     <= mag_a_q;
          loaded_q <= 1'b1;
        end else begin
          if (!div_diff[XLEN]) begin
            hi_q <= div_diff[XLEN-1:0];
            lo_q <= {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_q <= div_sh[XLEN-1:0];
            lo_q <= {lo_q[XLEN-2:0], 1'b0};
          end
          cnt_q <= cnt_q + CNT_W'(1);
        end
        ST_FIX: begin
          result_q <= fix_res;
          loaded_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_result = result_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// tb_ex_muldiv_seq: directed plus randomized checks of ex_muldiv_seq
// against a plain-arithmetic RV32M reference model.
module tb_ex_muldiv_seq;
  logic        i_clk   = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_flush = 1'b0;
  logic [2:0]  i_func3 = '0;
  logic [31:0] i_rs1   = '0;
  logic [31:0] i_rs2   = '0;
  logic        o_stall, o_busy, o_valid;
  logic [31:0] o_result;

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_exp = '0;

  always #5 i_clk = ~i_clk;

  ex_muldiv_seq #(.XLEN(32), .CNT_W(5)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_valid (i_valid),
    .i_func3 (i_func3),
    .i_rs1   (i_rs1),
    .i_rs2   (i_rs2),
    .i_flush (i_flush),
    .o_stall (o_stall),
    .o_busy  (o_busy),
    .o_valid (o_valid),
    .o_result(o_result)
  );

  // Protocol monitor: i_valid must stay up while an op is in flight.
  always begin
    @(negedge i_clk);
    #2;
    assert (!(i_reset && o_busy && !o_valid && !i_valid && !i_flush)) else begin
      failures++;
      $error("FAIL protocol i_valid dropped while busy observed=0 expected=1");
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (f)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one op and wait (bounded) for o_valid. lat counts edges after the accept edge.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit pre, input bit keep,
                        output int lat, output int stalls, output int busy, output logic [31:0] res);
    int e;
    bit got;
    if (!pre) @(negedge i_clk);
    i_valid = 1'b1; i_func3 = f; i_rs1 = a; i_rs2 = b;
    e = -1; stalls = 0; busy = 0; got = 1'b0; res = 'x; lat = -1;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (o_stall) stalls++;
      if (o_busy) busy++;
      if (o_valid) begin got = 1'b1; res = o_result; lat = e; break; end
      @(posedge i_clk); e++; @(negedge i_clk);
    end
    if (!got) check("timeout_o_valid", 64'd0, 64'd1);
    if (!keep) i_valid = 1'b0;
  endtask

  task automatic do_check(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit fast);
    int lat, stalls, busy;
    logic [31:0] res;
    run_op(f, a, b, 1'b0, 1'b0, lat, stalls, busy, res);
    check({tag, "_result"}, 64'(res), 64'(exp));
    check({tag, "_latency"}, 64'(lat), fast ? 64'd0 : 64'd34);
    check({tag, "_stall"}, 64'(stalls), fast ? 64'd1 : 64'd35);
    check({tag, "_busy"}, 64'(busy), fast ? 64'd1 : 64'd35);
    @(negedge i_clk); #1;
    check({tag, "_valid_width"}, 64'(o_valid), 64'd0);
    last_exp = exp;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] sp [5];
    sp = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    int lat, stalls, busy, nvalid;
    logic [31:0] res, a, b;
    logic [2:0]  f;
    bit fast;

    // Reset state
    #12;
    check("reset_busy", 64'(o_busy), 64'd0);
    check("reset_valid", 64'(o_valid), 64'd0);
    check("reset_result", 64'(o_result), 64'd0);
    @(negedge i_clk); i_reset = 1'b1;

    // Give o_result a nonzero value before the mid-op reset
    do_check("remu_div0", 3'b111, 32'd5, 32'd0, 32'd5, 1'b1);

    // Reset mid-MUL (counter at 10)
    @(negedge i_clk);
    i_valid = 1'b1; i_func3 = 3'b000; i_rs1 = 32'h0001_2345; i_rs2 = 32'h0000_6789;
    @(posedge i_clk);
    repeat (11) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0; i_valid = 1'b0;
    #1;
    check("midreset_busy", 64'(o_busy), 64'd0);
    check("midreset_valid", 64'(o_valid), 64'd0);
    check("midreset_result", 64'(o_result), 64'd0);
    repeat (3) @(negedge i_clk);
    i_reset = 1'b1;
    nvalid = 0;
    for (int k = 0; k < 40; k++) begin @(negedge i_clk); #1; if (o_valid) nvalid++; end
    check("midreset_no_valid", 64'(nvalid), 64'd0);
    do_check("mul_7x6", 3'b000, 32'd7, 32'd6, 32'h2A, 1'b0);

    // Directed multiplies and divides
    do_check("mulh_m1m1", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0);
    do_check("mulhu_m1m1", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    do_check("mulhsu_m1x2", 3'b010, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 1'b0);
    do_check("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    do_check("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    do_check("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 1'b0);
    do_check("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 1'b0);
    do_check("divu_div0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
    do_check("rem_div0", 3'b110, 32'd5, 32'd0, 32'd5, 1'b1);
    do_check("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    do_check("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1);

    // Flush at counter 15
    @(negedge i_clk);
    i_valid = 1'b1; i_func3 = 3'b101; i_rs1 = 32'd100; i_rs2 = 32'd7;
    nvalid = 0;
    @(posedge i_clk);
    for (int k = 0; k < 16; k++) begin @(negedge i_clk); #1; if (o_valid) nvalid++; @(posedge i_clk); end
    @(negedge i_clk);
    i_flush = 1'b1; i_valid = 1'b0;
    @(negedge i_clk);
    i_flush = 1'b0;
    #1;
    check("flush_busy", 64'(o_busy), 64'd0);
    for (int k = 0; k < 40; k++) begin @(negedge i_clk); #1; if (o_valid) nvalid++; end
    check("flush_no_valid", 64'(nvalid), 64'd0);
    check("flush_result_held", 64'(o_result), 64'(last_exp));
    do_check("mul_3x3", 3'b000, 32'd3, 32'd3, 32'd9, 1'b0);

    // Back-to-back: second op presented during the DONE cycle
    run_op(3'b000, 32'd2, 32'd3, 1'b0, 1'b1, lat, stalls, busy, res);
    check("b2b1_result", 64'(res), 64'd6);
    check("b2b1_latency", 64'(lat), 64'd34);
    i_func3 = 3'b000; i_rs1 = 32'd4; i_rs2 = 32'd5;
    @(posedge i_clk); @(negedge i_clk); #1;
    check("b2b_idle_gap_busy", 64'(o_busy), 64'd0);
    check("b2b1_valid_width", 64'(o_valid), 64'd0);
    run_op(3'b000, 32'd4, 32'd5, 1'b1, 1'b0, lat, stalls, busy, res);
    check("b2b2_result", 64'(res), 64'd20);
    check("b2b2_latency", 64'(lat), 64'd34);
    @(negedge i_clk); #1;
    check("b2b2_valid_width", 64'(o_valid), 64'd0);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      fast = f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      do_check($sformatf("rand%0d_f%0d", i, f), f, a, b, ref_op(f, a, b), fast);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
